// File: rtl/writeback_stage_pkg.sv
// Shared control encodings and the M->W pipeline payload for the writeback stage.
package writeback_stage_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned CNT_W      = 64;
    localparam int unsigned REG_IDX_W  = 5;
    localparam int unsigned RSRC_W     = 3;
    localparam int unsigned CSR_ADDR_W = 12;

    localparam logic [RSRC_W-1:0] RESULT_ALU      = 3'b000;
    localparam logic [RSRC_W-1:0] RESULT_MEM      = 3'b001;
    localparam logic [RSRC_W-1:0] RESULT_PCTARGET = 3'b010;
    localparam logic [RSRC_W-1:0] RESULT_PCPLUS4  = 3'b011;
    localparam logic [RSRC_W-1:0] RESULT_IMM_EXT  = 3'b100;
    localparam logic [RSRC_W-1:0] RESULT_CSR      = 3'b101;

    localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [CSR_ADDR_W-1:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [CSR_ADDR_W-1:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [CSR_ADDR_W-1:0] CSR_MINSTRETH = 12'hB82;

    typedef struct packed {
        logic                 valid;
        logic                 reg_write;
        logic                 csr_we;
        logic [RSRC_W-1:0]    result_src;
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      instr;
        logic [XLEN-1:0]      alu_result;
        logic [XLEN-1:0]      reduced_data;
        logic [XLEN-1:0]      pc_target;
        logic [XLEN-1:0]      pc_plus4;
        logic [XLEN-1:0]      imm_ext;
        logic [XLEN-1:0]      csr_rdata;
    } mw_reg_t;

endpackage

// File: rtl/retire_counters.sv
// mcycle / minstret counters with CSR-write override from the retiring instruction.
module retire_counters
    import writeback_stage_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  retire_i,
    input  logic                  csr_we_i,
    input  logic [CSR_ADDR_W-1:0] csr_addr_i,
    input  logic [XLEN-1:0]       csr_wdata_i,
    output logic [CNT_W-1:0]      mcycle_o,
    output logic [CNT_W-1:0]      minstret_o
);

    logic             csr_hit;
    logic [CNT_W-1:0] mcycle_q, mcycle_d;
    logic [CNT_W-1:0] minstret_q, minstret_d;

    // A written half replaces the increment; the other half holds without carry.
    always_comb begin
        csr_hit    = csr_we_i & retire_i;
        mcycle_d   = mcycle_q + CNT_W'(1);
        minstret_d = minstret_q + CNT_W'(retire_i);
        if (csr_hit) begin
            case (csr_addr_i)
                CSR_MCYCLE:    mcycle_d   = {mcycle_q[CNT_W-1:XLEN], csr_wdata_i};
                CSR_MCYCLEH:   mcycle_d   = {csr_wdata_i, mcycle_q[XLEN-1:0]};
                CSR_MINSTRET:  minstret_d = {minstret_q[CNT_W-1:XLEN], csr_wdata_i};
                CSR_MINSTRETH: minstret_d = {csr_wdata_i, minstret_q[XLEN-1:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    assign mcycle_o   = mcycle_q;
    assign minstret_o = minstret_q;

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: M->W register, write-back result select, retirement and counters.
module writeback_stage
    import writeback_stage_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [XLEN-1:0]      instr_m_i,
    input  logic                 valid_m_i,
    input  logic [XLEN-1:0]      alu_result_m_i,
    input  logic [XLEN-1:0]      reduced_data_m_i,
    input  logic [XLEN-1:0]      pc_target_m_i,
    input  logic [XLEN-1:0]      pc_plus4_m_i,
    input  logic [XLEN-1:0]      imm_ext_m_i,
    input  logic [XLEN-1:0]      csr_rdata_m_i,
    input  logic [REG_IDX_W-1:0] rd_m_i,
    input  logic [RSRC_W-1:0]    result_src_m_i,
    input  logic                 reg_write_m_i,
    input  logic                 csr_we_m_i,
    input  logic                 stall_w_i,
    input  logic                 flush_w_i,
    output logic [XLEN-1:0]      instr_w_o,
    output logic [XLEN-1:0]      result_w_o,
    output logic [REG_IDX_W-1:0] rd_w_o,
    output logic                 reg_write_w_o,
    output logic                 valid_w_o,
    output logic                 retire_w_o,
    output logic [CNT_W-1:0]     mcycle_o,
    output logic [CNT_W-1:0]     minstret_o
);

    mw_reg_t m_d;
    mw_reg_t w_q;

    always_comb begin
        m_d              = '0;
        m_d.valid        = valid_m_i;
        m_d.reg_write    = reg_write_m_i;
        m_d.csr_we       = csr_we_m_i;
        m_d.result_src   = result_src_m_i;
        m_d.rd           = rd_m_i;
        m_d.instr        = instr_m_i;
        m_d.alu_result   = alu_result_m_i;
        m_d.reduced_data = reduced_data_m_i;
        m_d.pc_target    = pc_target_m_i;
        m_d.pc_plus4     = pc_plus4_m_i;
        m_d.imm_ext      = imm_ext_m_i;
        m_d.csr_rdata    = csr_rdata_m_i;
    end

    // Flush beats stall; clearing the whole payload also clears the control fields.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            w_q <= '0;
        end else if (flush_w_i) begin
            w_q <= '0;
        end else if (!stall_w_i) begin
            w_q <= m_d;
        end
    end

    always_comb begin
        result_w_o = '0;
        case (w_q.result_src)
            RESULT_ALU:      result_w_o = w_q.alu_result;
            RESULT_MEM:      result_w_o = w_q.reduced_data;
            RESULT_PCTARGET: result_w_o = w_q.pc_target;
            RESULT_PCPLUS4:  result_w_o = w_q.pc_plus4;
            RESULT_IMM_EXT:  result_w_o = w_q.imm_ext;
            RESULT_CSR:      result_w_o = w_q.csr_rdata;
            default:         result_w_o = '0;
        endcase
    end

    assign instr_w_o     = w_q.instr;
    assign rd_w_o        = w_q.rd;
    assign valid_w_o     = w_q.valid;
    assign reg_write_w_o = w_q.reg_write & w_q.valid;
    assign retire_w_o    = w_q.valid & ~stall_w_i;

    retire_counters u_retire_counters (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .retire_i    (retire_w_o),
        .csr_we_i    (w_q.csr_we),
        .csr_addr_i  (w_q.instr[XLEN-1:XLEN-CSR_ADDR_W]),
        .csr_wdata_i (w_q.alu_result),
        .mcycle_o    (mcycle_o),
        .minstret_o  (minstret_o)
    );

endmodule
